// File: rtl/div_issue_ctrl_pkg.sv
// Shared opcode constants, FSM state type and opcode decode helper
// for the EX-stage divider issue controller.
package div_issue_ctrl_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_START = 2'd1;
    localparam logic [1:0] ENC_BUSY  = 2'd2;
    localparam logic [1:0] ENC_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_START = ENC_START,
        ST_BUSY  = ENC_BUSY,
        ST_DONE  = ENC_DONE
    } div_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU to the multi-cycle divider, stalls EX until the result
// returns, and converts the result into single HI/LO write pulses.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 7
) (
    input  logic        clk,
    input  logic        sclr,
    input  logic        ex_valid,
    input  logic [7:0]  ex_alucontrol,
    input  logic [31:0] ex_srca,
    input  logic [31:0] ex_srcb,
    input  logic        ex_advance,
    input  logic        flush,
    input  logic        div_ok,
    input  logic [63:0] div_result,
    output logic        div_sclr,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic [7:0]  div_op,
    output logic        stall_div,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        div_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [7:0]       op_q;
    logic             abort_q;
    logic             hi_we_q;
    logic             lo_we_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             timeout_q;

    logic             is_div;
    logic             start_req;

    assign is_div    = ex_valid & is_div_op(ex_alucontrol);
    assign start_req = is_div & ~flush;

    // op_q is loaded on entry to START and cleared on every other edge,
    // so it is nonzero for exactly the one START cycle.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            abort_q   <= 1'b0;
            hi_we_q   <= 1'b0;
            lo_we_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            op_q    <= '0;
            abort_q <= 1'b0;
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        a_q     <= ex_srca;
                        b_q     <= ex_srcb;
                        op_q    <= ex_alucontrol;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q <= '0;
                    if (flush) begin
                        abort_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        abort_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (div_ok) begin
                        hi_q    <= div_result[63:32];
                        lo_q    <= div_result[31:0];
                        hi_we_q <= 1'b1;
                        lo_we_q <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        abort_q   <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Hold here until EX actually moves on so a stalled divide is not reissued.
                    if (flush || ex_advance) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_div   = ((state_q == ST_IDLE) & start_req) |
                         (state_q == ST_START) |
                         (state_q == ST_BUSY);
    assign div_sclr    = sclr | abort_q;
    assign div_a       = a_q;
    assign div_b       = b_q;
    assign div_op      = op_q;
    assign hi_we       = hi_we_q;
    assign lo_we       = lo_we_q;
    assign hi_wdata    = hi_q;
    assign lo_wdata    = lo_q;
    assign div_timeout = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed scenarios plus randomized
// divide transactions checked against a cycle-timeline model of each divide.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    localparam int MAX_WAIT = 64;
    localparam int CNT_W    = 7;

    logic        clk;
    logic        sclr;
    logic        ex_valid;
    logic [7:0]  ex_alucontrol;
    logic [31:0] ex_srca;
    logic [31:0] ex_srcb;
    logic        ex_advance;
    logic        flush;
    logic        div_ok;
    logic [63:0] div_result;
    logic        div_sclr;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [7:0]  div_op;
    logic        stall_div;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        div_timeout;

    int vectorCount = 0;
    int missCount   = 0;
    bit expTimeout  = 1'b0;

    div_issue_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .sclr(sclr), .ex_valid(ex_valid), .ex_alucontrol(ex_alucontrol),
        .ex_srca(ex_srca), .ex_srcb(ex_srcb), .ex_advance(ex_advance), .flush(flush),
        .div_ok(div_ok), .div_result(div_result), .div_sclr(div_sclr), .div_a(div_a),
        .div_b(div_b), .div_op(div_op), .stall_div(stall_div), .hi_we(hi_we),
        .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .div_timeout(div_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic toNext();
        @(posedge clk);
        #1;
    endtask

    // Divider behaviour: {remainder, quotient}; divide-by-zero returns an arbitrary pattern.
    function automatic logic [63:0] refDivide(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hffff_ffff};
        if (op == EXE_DIV_OP) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [7:0] randNonDivOp();
        logic [7:0] op;
        op = 8'($urandom);
        while (op == EXE_DIV_OP || op == EXE_DIVU_OP) op = 8'($urandom);
        return op;
    endfunction

    task automatic applyReset();
        sclr = 1'b1; ex_valid = 1'b0; ex_alucontrol = '0; ex_srca = $urandom; ex_srcb = $urandom;
        ex_advance = 1'b0; flush = 1'b0; div_ok = 1'b0; div_result = '0;
        toNext();
        toNext();
        @(negedge clk);
        expTimeout = 1'b0;
        checkOutput("rst_div_sclr", 64'(div_sclr), 64'd1);
        checkOutput("rst_div_a", 64'(div_a), 64'd0);
        checkOutput("rst_div_b", 64'(div_b), 64'd0);
        checkOutput("rst_div_op", 64'(div_op), 64'd0);
        checkOutput("rst_we", 64'({hi_we, lo_we}), 64'd0);
        checkOutput("rst_wdata", {hi_wdata, lo_wdata}, 64'd0);
        checkOutput("rst_timeout", 64'(div_timeout), 64'd0);
        checkOutput("rst_stall", 64'(stall_div), 64'd0);
        toNext();
        sclr = 1'b0;
    endtask

    // Non-divide or empty EX cycles with stray div_ok: nothing may happen.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            ex_valid = 1'($urandom); ex_alucontrol = randNonDivOp(); ex_advance = 1'b1;
            flush = 1'b0; div_ok = 1'($urandom); div_result = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("idle_stall", 64'(stall_div), 64'd0);
            checkOutput("idle_div_op", 64'(div_op), 64'd0);
            checkOutput("idle_we", 64'({hi_we, lo_we}), 64'd0);
            toNext();
        end
        div_ok = 1'b0;
    endtask

    // One divide in EX. lat: BUSY cycle index in which the DU answers (<0 never).
    // flushAt: BUSY index at which flush is asserted, -2 flushes in START, -1 none.
    // hold: DONE cycles with ex_advance low before EX advances.
    task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int lat, input int hold, input int flushAt);
        logic [63:0] res;
        int outcome;
        res = refDivide(op, a, b);
        outcome = 2;

        ex_valid = 1'b1; ex_alucontrol = op; ex_srca = a; ex_srcb = b;
        ex_advance = 1'b0; flush = 1'b0; div_ok = 1'b0; div_result = {$urandom, $urandom};
        @(negedge clk);
        checkOutput("detect_stall", 64'(stall_div), 64'd1);
        checkOutput("detect_div_op", 64'(div_op), 64'd0);
        toNext();

        ex_srca = $urandom; ex_srcb = $urandom; div_ok = 1'($urandom);
        flush = (flushAt == -2);
        @(negedge clk);
        checkOutput("start_div_op", 64'(div_op), 64'(op));
        checkOutput("start_stall", 64'(stall_div), 64'd1);
        checkOutput("start_operands", {div_a, div_b}, {a, b});
        checkOutput("start_div_sclr", 64'(div_sclr), 64'd0);
        toNext();

        if (flushAt == -2) begin
            outcome = 1;
        end else begin
            for (int i = 0; i < MAX_WAIT; i++) begin
                div_ok = (i == lat);
                flush = (i == flushAt);
                div_result = div_ok ? res : {$urandom, $urandom};
                ex_srca = $urandom; ex_srcb = $urandom;
                @(negedge clk);
                checkOutput("busy_stall", 64'(stall_div), 64'd1);
                checkOutput("busy_div_op", 64'(div_op), 64'd0);
                checkOutput("busy_operands", {div_a, div_b}, {a, b});
                checkOutput("busy_div_sclr", 64'(div_sclr), 64'd0);
                checkOutput("busy_we", 64'({hi_we, lo_we}), 64'd0);
                checkOutput("busy_timeout", 64'(div_timeout), 64'(expTimeout));
                toNext();
                if (flush) begin outcome = 1; break; end
                if (div_ok) begin outcome = 0; break; end
            end
        end

        if (outcome == 1) begin
            ex_valid = 1'b0; flush = 1'b0; div_ok = 1'b0;
            @(negedge clk);
            checkOutput("abort_div_sclr", 64'(div_sclr), 64'd1);
            checkOutput("abort_stall", 64'(stall_div), 64'd0);
            checkOutput("abort_we", 64'({hi_we, lo_we}), 64'd0);
            toNext();
            div_ok = 1'b1; div_result = res;
            @(negedge clk);
            checkOutput("abort_sclr_once", 64'(div_sclr), 64'd0);
            checkOutput("abort_late_ok_we", 64'({hi_we, lo_we}), 64'd0);
            toNext();
            div_ok = 1'b0;
            @(negedge clk);
            checkOutput("abort_after_ok_we", 64'({hi_we, lo_we}), 64'd0);
            checkOutput("abort_stall_idle", 64'(stall_div), 64'd0);
            toNext();
        end else begin
            if (outcome == 2) expTimeout = 1'b1;
            for (int j = 0; j <= hold; j++) begin
                ex_srca = a; ex_srcb = b; flush = 1'b0;
                ex_advance = (j == hold);
                div_ok = 1'($urandom); div_result = {$urandom, $urandom};
                @(negedge clk);
                checkOutput("done_stall", 64'(stall_div), 64'd0);
                checkOutput("done_div_op", 64'(div_op), 64'd0);
                checkOutput("done_timeout", 64'(div_timeout), 64'(expTimeout));
                if (j == 0 && outcome == 0) begin
                    checkOutput("done_we", 64'({hi_we, lo_we}), 64'd3);
                    checkOutput("done_wdata", {hi_wdata, lo_wdata}, res);
                    checkOutput("done_div_sclr", 64'(div_sclr), 64'd0);
                end else if (j == 0) begin
                    checkOutput("timeout_we", 64'({hi_we, lo_we}), 64'd0);
                    checkOutput("timeout_div_sclr", 64'(div_sclr), 64'd1);
                end else begin
                    checkOutput("hold_we", 64'({hi_we, lo_we}), 64'd0);
                    checkOutput("hold_div_sclr", 64'(div_sclr), 64'd0);
                    if (outcome == 0) checkOutput("hold_wdata", {hi_wdata, lo_wdata}, res);
                end
                toNext();
            end
            div_ok = 1'b0; ex_advance = 1'b0;
        end
    endtask

    initial begin
        logic [7:0]  rOp;
        logic [31:0] rA, rB;
        int rLat, rHold, rFlush;

        applyReset();
        idleCycles(3);

        applyStimulus(EXE_DIV_OP, 32'hffff_fffd, 32'd2, 38, 0, -1);
        idleCycles(1);
        applyStimulus(EXE_DIVU_OP, 32'hffff_fffd, 32'hffff_fff0, 38, 0, -1);
        idleCycles(1);
        applyStimulus(EXE_DIV_OP, 32'd255, 32'd16, 12, 5, -1);
        idleCycles(1);
        applyStimulus(EXE_DIV_OP, 32'd1000, 32'd7, 20, 0, 10);
        applyStimulus(EXE_DIVU_OP, 32'd1000, 32'd7, 5, 0, 5);
        applyStimulus(EXE_DIV_OP, 32'd99, 32'd4, 3, 0, -2);
        applyStimulus(EXE_DIVU_OP, 32'd77, 32'd0, 4, 1, -1);
        applyStimulus(EXE_DIV_OP, 32'h1234_5678, 32'd3, -1, 2, -1);
        applyStimulus(EXE_DIVU_OP, 32'd50, 32'd6, 9, 0, -1);
        applyReset();
        applyStimulus(EXE_DIV_OP, 32'd200, 32'hffff_fffb, 30, 0, -1);
        applyStimulus(EXE_DIVU_OP, 32'd200, 32'd9, 25, 0, -1);
        idleCycles(2);

        for (int t = 0; t < 30; t++) begin
            rOp = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
            rA = $urandom;
            rB = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rLat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 45);
            rHold = $urandom_range(0, 3);
            rFlush = -1;
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 3) == 0) rFlush = -2;
                else rFlush = (rLat >= 0) ? $urandom_range(0, rLat) : $urandom_range(0, MAX_WAIT - 1);
            end
            applyStimulus(rOp, rA, rB, rLat, rHold, rFlush);
            if ($urandom_range(0, 7) == 0) applyReset();
            idleCycles($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
